// File: rtl/toggle_mon_pkg.sv
// Shared state encoding for toggle_monitor and anything that decodes its state output.
package toggle_mon_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus history flop; emits a registered one-cycle pulse on
// either edge of an asynchronous input, three clocks after the input changes.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync_1;
    logic sync_2;
    logic hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            hist       <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync_1     <= async_in;
            sync_2     <= sync_1;
            hist       <= sync_2;
            edge_pulse <= sync_2 ^ hist;
        end
    end

endmodule

// File: rtl/toggle_monitor.sv
// Measures the interval between transitions of an asynchronous toggle, classifies it
// against a window and flags loss of toggling. TOGGLE_MON_STATS_EN adds min/max/error stats.
module toggle_monitor
    import toggle_mon_pkg::*;
#(
    parameter int unsigned CNT_BITS    = 24,
    parameter int unsigned MIN_PERIOD  = 11000000,
    parameter int unsigned MAX_PERIOD  = 13000000,
    parameter int unsigned TIMEOUT     = 16000000,
    parameter int unsigned GOOD_NEEDED = 2
) (
    input  logic                clk_12mhz,
    input  logic                rst_n,
    input  logic                toggle_in,
    output logic [CNT_BITS-1:0] period,
    output logic                period_valid,
    output logic                in_range,
    output logic                timeout,
    output logic [STATE_W-1:0]  state,
`ifdef TOGGLE_MON_STATS_EN
    output logic [CNT_BITS-1:0] min_period,
    output logic [CNT_BITS-1:0] max_period,
    output logic [15:0]         err_count,
`endif
    output logic                led_ok,
    output logic                led_fault
);

    localparam int unsigned GW = $clog2(GOOD_NEEDED + 1);
    localparam logic [CNT_BITS-1:0] TO   = CNT_BITS'(TIMEOUT);
    localparam logic [CNT_BITS-1:0] MINP = CNT_BITS'(MIN_PERIOD);
    localparam logic [CNT_BITS-1:0] MAXP = CNT_BITS'(MAX_PERIOD);
    localparam logic [GW-1:0]       GN   = GW'(GOOD_NEEDED);

    state_t              st;
    state_t              st_nxt;
    logic                tgl_edge;
    logic [CNT_BITS-1:0] count;
    logic [GW-1:0]       good_cnt;
    logic [GW-1:0]       good_inc;
    logic                in_win;
    logic                at_limit;

    sync_edge_detect u_sync (
        .clk        (clk_12mhz),
        .rst_n      (rst_n),
        .async_in   (toggle_in),
        .edge_pulse (tgl_edge)
    );

    assign in_win   = (count >= MINP) && (count <= MAXP);
    assign at_limit = (count == TO - 1'b1);
    assign good_inc = (good_cnt == GN) ? GN : good_cnt + 1'b1;
    assign state    = st;

    // An edge always beats a coinciding timeout; the first edge after a timeout only re-arms.
    always_comb begin
        st_nxt = st;
        if (tgl_edge) begin
            if (st == IDLE) begin
                st_nxt = ARMED;
            end else if (!timeout) begin
                if (!in_win)
                    st_nxt = FAULT;
                else if (good_inc == GN)
                    st_nxt = LOCKED;
            end
        end else if (at_limit) begin
            st_nxt = FAULT;
        end
    end

    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            st           <= IDLE;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            in_range     <= 1'b0;
            timeout      <= 1'b0;
            good_cnt     <= '0;
            led_ok       <= 1'b0;
            led_fault    <= 1'b0;
`ifdef TOGGLE_MON_STATS_EN
            min_period   <= '0;
            max_period   <= '0;
            err_count    <= '0;
`endif
        end else begin
            st           <= st_nxt;
            led_ok       <= (st_nxt == LOCKED);
            led_fault    <= (st_nxt == FAULT);
            period_valid <= 1'b0;
            if (tgl_edge) begin
                count <= CNT_BITS'(1);
                if (timeout) begin
                    timeout <= 1'b0;
                end else if (st != IDLE) begin
                    period       <= count;
                    period_valid <= 1'b1;
                    in_range     <= in_win;
                    good_cnt     <= in_win ? good_inc : '0;
`ifdef TOGGLE_MON_STATS_EN
                    // A measured interval is never zero, so zero marks an unloaded minimum.
                    if (min_period == '0 || count < min_period)
                        min_period <= count;
                    if (count > max_period)
                        max_period <= count;
                    if (!in_win && err_count != '1)
                        err_count <= err_count + 1'b1;
`endif
                end
            end else begin
                if (count != TO)
                    count <= count + 1'b1;
                if (at_limit) begin
                    timeout  <= 1'b1;
                    good_cnt <= '0;
                    in_range <= 1'b0;
`ifdef TOGGLE_MON_STATS_EN
                    if (err_count != '1)
                        err_count <= err_count + 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_toggle_monitor.sv
// Scoreboard bench for toggle_monitor; define TOGGLE_MON_STATS_EN to also cover the stats outputs.
module tb_toggle_monitor;
    import toggle_mon_pkg::*;

    localparam int CNT_BITS = 8;
    localparam int MINP     = 18;
    localparam int MAXP     = 22;
    localparam int TMO      = 40;
    localparam int GOOD     = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                toggle_in = 1'b0;
    logic [CNT_BITS-1:0] period;
    logic                period_valid;
    logic                in_range;
    logic                timeout;
    logic [1:0]          state;
    logic                led_ok;
    logic                led_fault;
`ifdef TOGGLE_MON_STATS_EN
    logic [CNT_BITS-1:0] min_period;
    logic [CNT_BITS-1:0] max_period;
    logic [15:0]         err_count;
`endif

    toggle_monitor #(
        .CNT_BITS    (CNT_BITS),
        .MIN_PERIOD  (MINP),
        .MAX_PERIOD  (MAXP),
        .TIMEOUT     (TMO),
        .GOOD_NEEDED (GOOD)
    ) dut (
        .clk_12mhz    (clk),
        .rst_n        (rst_n),
        .toggle_in    (toggle_in),
        .period       (period),
        .period_valid (period_valid),
        .in_range     (in_range),
        .timeout      (timeout),
        .state        (state),
`ifdef TOGGLE_MON_STATS_EN
        .min_period   (min_period),
        .max_period   (max_period),
        .err_count    (err_count),
`endif
        .led_ok       (led_ok),
        .led_fault    (led_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     period;
        logic   inr;
        state_t st;
        int     due;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     gap = 0;
    state_t mst = IDLE;
    int     mgood = 0;
    logic   mto = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && period_valid) begin
            if (sb.size() == 0) begin
                check("pv_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pv_latency", cyc, e.due);
                check("period", period, e.period);
                check("in_range", in_range, e.inr);
                check("state_at_pv", state, e.st);
                check("timeout_at_pv", timeout, 0);
                check("led_ok_at_pv", led_ok, e.st == LOCKED);
                check("led_fault_at_pv", led_fault, e.st == FAULT);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
        gap += n;
    endtask

    // Flip toggle_in so that the interval since the previous flip is n cycles, and model the outcome.
    task automatic toggle_at(input int n);
        exp_t e;
        logic inr;
        if (n > gap) wait_cycles(n - gap);
        toggle_in = ~toggle_in;
        if (mst != IDLE && n >= TMO) begin
            mto   = 1'b1;
            mst   = FAULT;
            mgood = 0;
        end
        if (mst == IDLE) begin
            mst = ARMED;
        end else if (mto) begin
            mto = 1'b0;
        end else begin
            inr = (n >= MINP) && (n <= MAXP);
            if (inr) begin
                if (mgood < GOOD) mgood++;
                if (mgood == GOOD) mst = LOCKED;
            end else begin
                mgood = 0;
                mst   = FAULT;
            end
            e.period = n;
            e.inr    = inr;
            e.st     = mst;
            e.due    = cyc + 4;
            sb.push_back(e);
        end
        gap = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        toggle_in = 1'b0;
        #1;
        check("rst_period", period, 0);
        check("rst_pv", period_valid, 0);
        check("rst_in_range", in_range, 0);
        check("rst_timeout", timeout, 0);
        check("rst_state", state, IDLE);
        check("rst_led_ok", led_ok, 0);
        check("rst_led_fault", led_fault, 0);
`ifdef TOGGLE_MON_STATS_EN
        check("rst_min", min_period, 0);
        check("rst_max", max_period, 0);
        check("rst_err", err_count, 0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        mst   = IDLE;
        mgood = 0;
        mto   = 1'b0;
        gap   = 0;
    endtask

    initial begin
        apply_reset();

        toggle_at(3);
        wait_cycles(4);
        check("armed_after_first", state, ARMED);
        repeat (3) toggle_at(20);
        wait_cycles(5);
        check("led_ok_locked", led_ok, 1);

        toggle_at(25);
        toggle_at(20);
        toggle_at(20);

        toggle_at(18);
        toggle_at(22);
        toggle_at(17);
        toggle_at(23);
        toggle_at(TMO - 1);
        toggle_at(20);
        toggle_at(20);

        wait_cycles(42);
        check("no_timeout_yet", timeout, 0);
        check("locked_before_to", state, LOCKED);
        wait_cycles(1);
        check("timeout_set", timeout, 1);
        check("fault_on_to", state, FAULT);
        check("led_fault_to", led_fault, 1);
        check("led_ok_to", led_ok, 0);
        toggle_at(50);
        wait_cycles(4);
        check("timeout_cleared", timeout, 0);
        check("fault_after_to", state, FAULT);
        toggle_at(20);
        toggle_at(20);

        wait_cycles(10);
        apply_reset();
        toggle_at(3);
        wait_cycles(4);
        check("armed_after_rst", state, ARMED);
        toggle_at(20);

        wait_cycles(8);
        apply_reset();
        toggle_at(3);
        toggle_at(20);
        toggle_at(19);
        toggle_at(23);
        wait_cycles(45);
        check("final_timeout", timeout, 1);
        check("final_state", state, FAULT);
`ifdef TOGGLE_MON_STATS_EN
        check("stat_min", min_period, 19);
        check("stat_max", max_period, 23);
        check("stat_err", err_count, 2);
`endif
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
